// File: rtl/vga_sync_if.sv
// vga_sync_if: video timing bundle produced by vga_sync and consumed by the display side.
interface vga_sync_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [11:0] rgb;
  modport master (output hsync, vsync, video_on, frame_start, pixel_x, pixel_y, rgb);
  modport slave  (input  hsync, vsync, video_on, frame_start, pixel_x, pixel_y, rgb);
endinterface

// File: rtl/vga_sync.sv
// vga_sync: VGA timing generator that runs only while the pixel clock is locked.
// Define VGA_SYNC_TEST_PATTERN_EN to drive eight vertical colour bars on rgb.
module vga_sync #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic clk25,
  input  logic reset,
  input  logic locked,
  vga_sync_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] X_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {WAIT_LOCK, RUN} state_t;

  state_t     r_state, w_state_n;
  logic [1:0] r_sync;
  logic       w_locked_s;
  logic [9:0] r_x, r_y, w_x_n, w_y_n;
  logic       r_hsync, r_vsync, r_video, r_fs;
  logic       w_run_n, w_hs_n, w_vs_n, w_video_n, w_fs_n;

  assign w_locked_s = r_sync[1];

  always_ff @(posedge clk25 or posedge reset)
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[0], locked};

  always_ff @(posedge clk25 or posedge reset)
    if (reset) r_state <= WAIT_LOCK;
    else       r_state <= w_state_n;

  // Outputs are computed from next-cycle counters so every registered output matches pixel_x/pixel_y.
  always_comb begin
    w_state_n = w_locked_s ? RUN : WAIT_LOCK;
    w_run_n   = w_state_n == RUN;
    w_x_n     = '0;
    w_y_n     = '0;
    if (w_run_n && r_state == RUN) begin
      w_x_n = (r_x == X_MAX) ? '0 : r_x + 10'd1;
      w_y_n = (r_x != X_MAX) ? r_y : (r_y == Y_MAX) ? '0 : r_y + 10'd1;
    end
    w_hs_n    = !(w_run_n && w_x_n >= HS_BEG && w_x_n < HS_END);
    w_vs_n    = !(w_run_n && w_y_n >= VS_BEG && w_y_n < VS_END);
    w_video_n = w_run_n && w_x_n < X_ACT && w_y_n < Y_ACT;
    w_fs_n    = w_run_n && w_x_n == '0 && w_y_n == '0;
  end

  always_ff @(posedge clk25 or posedge reset)
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_video <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_x     <= w_x_n;
      r_y     <= w_y_n;
      r_hsync <= w_hs_n;
      r_vsync <= w_vs_n;
      r_video <= w_video_n;
      r_fs    <= w_fs_n;
    end

  assign vga.pixel_x     = r_x;
  assign vga.pixel_y     = r_y;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.video_on    = r_video;
  assign vga.frame_start = r_fs;

`ifdef VGA_SYNC_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [11:0] PAL [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                      12'hF0F, 12'hF00, 12'h00F, 12'h000};
  logic [2:0]  w_bar;
  logic [11:0] r_rgb;

  always_comb begin
    w_bar = '0;
    for (int k = 1; k < 8; k++)
      if (w_x_n >= 10'(k * BAR_W)) w_bar = w_bar + 3'd1;
  end

  always_ff @(posedge clk25 or posedge reset)
    if (reset) r_rgb <= '0;
    else       r_rgb <= w_video_n ? PAL[w_bar] : '0;

  assign vga.rgb = r_rgb;
`else
  assign vga.rgb = '0;
`endif
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: directed checks of lock-up, line/frame timing, lock loss, async reset and rgb.
module tb_vga_sync;
  logic clk25 = 1'b0;
  logic reset = 1'b1;
  logic locked = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  vga_sync_if vga();

  // Full horizontal timing, shortened vertical timing: 12 lines x 800 = 9600 cycles per frame.
  vga_sync #(.V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut (
    .clk25(clk25), .reset(reset), .locked(locked), .vga(vga)
  );

  always #20 clk25 = ~clk25;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk25);
  endtask

  task automatic wait_xy(input string tag, input int x, input int y);
    int n = 0;
    while (!(int'(vga.pixel_x) == x && int'(vga.pixel_y) == y) && n < 20000) begin
      @(negedge clk25);
      n++;
    end
    check(tag, n < 20000, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_x"},  vga.pixel_x, 0);
    check({tag, "_y"},  vga.pixel_y, 0);
    check({tag, "_hs"}, vga.hsync, 1);
    check({tag, "_vs"}, vga.vsync, 1);
    check({tag, "_von"}, vga.video_on, 0);
    check({tag, "_fs"}, vga.frame_start, 0);
    check({tag, "_rgb"}, vga.rgb, 0);
  endtask

  initial begin
    int hlow, hfirst, von, vlow, vfirst, c;
    cyc(3);
    check_idle("rst");
    reset = 1'b0;
    cyc(3);
    check("nolock_x", vga.pixel_x, 0);
    check("nolock_fs", vga.frame_start, 0);

    locked = 1'b1;
    cyc(1);
    check("lock_k_fs", vga.frame_start, 0);
    cyc(1);
    check("lock_k1_fs", vga.frame_start, 0);
    cyc(1);
    check("lock_k2_fs", vga.frame_start, 1);
    check("lock_k2_x", vga.pixel_x, 0);
    check("lock_k2_y", vga.pixel_y, 0);
    check("lock_k2_von", vga.video_on, 1);
    check("lock_k2_hs", vga.hsync, 1);

    hlow = 0; hfirst = -1; von = 0;
    for (int i = 0; i < 800; i++) begin
      if (!vga.hsync) begin
        hlow++;
        if (hfirst < 0) hfirst = int'(vga.pixel_x);
      end
      if (vga.video_on) von++;
      @(negedge clk25);
    end
    check("line_hlow", hlow, 96);
    check("line_hfirst", hfirst, 656);
    check("line_von", von, 640);
    check("line_wrap_x", vga.pixel_x, 0);
    check("line_wrap_y", vga.pixel_y, 1);

    vlow = 0; vfirst = -1; von = 0; c = 0;
    while (!vga.frame_start && c < 20000) begin
      if (!vga.vsync) begin
        vlow++;
        if (vfirst < 0) vfirst = int'(vga.pixel_y);
      end
      if (vga.video_on) von++;
      @(negedge clk25);
      c++;
    end
    check("frame_period", 800 + c, 9600);
    check("frame_vlow", vlow, 1600);
    check("frame_vfirst", vfirst, 8);
    check("frame_von", von, 3200);
    check("frame_fs_x", vga.pixel_x, 0);
    check("frame_fs_y", vga.pixel_y, 0);
    cyc(1);
    check("fs_pulse_end", vga.frame_start, 0);
    check("fs_next_x", vga.pixel_x, 1);

    wait_xy("reach_300_3", 300, 3);
    locked = 1'b0;
    cyc(1);
    check("loss_a_x", vga.pixel_x, 301);
    cyc(1);
    check("loss_a1_x", vga.pixel_x, 302);
    cyc(1);
    check_idle("loss");
    cyc(3);
    check("loss_hold_x", vga.pixel_x, 0);
    locked = 1'b1;
    cyc(2);
    check("relock_k1_fs", vga.frame_start, 0);
    cyc(1);
    check("relock_fs", vga.frame_start, 1);
    check("relock_x", vga.pixel_x, 0);
    check("relock_y", vga.pixel_y, 0);
    cyc(1);
    check("relock_next_x", vga.pixel_x, 1);

    wait_xy("reach_700_4", 700, 4);
    check("pre_rst_hs", vga.hsync, 0);
    #3 reset = 1'b1;
    #1 check_idle("arst");
    @(negedge clk25);
    reset = 1'b0;
    cyc(1);
    check("rst_rel1_fs", vga.frame_start, 0);
    check("rst_rel1_x", vga.pixel_x, 0);
    cyc(1);
    check("rst_rel2_fs", vga.frame_start, 0);
    cyc(1);
    check("rst_rel3_fs", vga.frame_start, 1);

`ifdef VGA_SYNC_TEST_PATTERN_EN
    check("rgb_x0", vga.rgb, 12'hFFF);
    wait_xy("reach_79_0", 79, 0);
    check("rgb_x79", vga.rgb, 12'hFFF);
    cyc(1);
    check("rgb_x80", vga.rgb, 12'hFF0);
    wait_xy("reach_160_0", 160, 0);
    check("rgb_x160", vga.rgb, 12'h0FF);
    wait_xy("reach_639_0", 639, 0);
    check("rgb_x639", vga.rgb, 12'h000);
    cyc(1);
    check("rgb_x640", vga.rgb, 12'h000);
    check("rgb_x640_von", vga.video_on, 0);
`else
    check("rgb_x0", vga.rgb, 0);
    wait_xy("reach_80_0", 80, 0);
    check("rgb_x80", vga.rgb, 0);
    check("rgb_x80_von", vga.video_on, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
